// File: rtl/sdec_bi_cnt.sv
// sdec_bi_cnt: bipolar stochastic-to-binary decoder.
// Counts ones over a window of 2^INWD valid bits and reports the signed
// bipolar value oC = ones - 2^(INWD-1) with a one-cycle oDone pulse.
// Build option: define SDEC_BI_CONT_EN for continuous mode (back-to-back
// windows after a single start); undefined gives single-shot windows.
module sdec_bi_cnt #(
    parameter int INWD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              iBit,
    input  logic              iValid,
    output logic              oBusy,
    output logic              oDone,
    output logic signed [INWD:0] oC
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Half-scale offset that maps the ones count onto the signed bipolar range.
    localparam logic [INWD:0] HALF_C = (INWD+1)'(1) << (INWD-1);
    // Sample index of the final bit in a window.
    localparam logic [INWD:0] LAST_C = (INWD+1)'((1 << INWD) - 1);
    localparam logic [INWD:0] ZERO_C = {(INWD+1){1'b0}};
    localparam logic [INWD:0] ONE_C  = (INWD+1)'(1);

    state_t          state_r;
    state_t          state_s;
    logic [INWD:0]   cnt_r;
    logic [INWD:0]   cnt_s;
    logic [INWD:0]   ones_r;
    logic [INWD:0]   ones_s;
    logic [INWD:0]   ones_inc_s;
    logic [INWD:0]   oc_r;
    logic [INWD:0]   oc_s;
    logic            done_r;
    logic            done_s;
    logic            busy_r;

    // Ones count including the bit presented this cycle.
    assign ones_inc_s = ones_r + {{INWD{1'b0}}, iBit};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, counter updates and window completion.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ones_s  = ones_r;
        oc_s    = oc_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACC;
                    cnt_s   = ZERO_C;
                    ones_s  = ZERO_C;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (iValid) begin
                    if (cnt_r == LAST_C) begin
                        // N-th valid bit: publish result and restart counting.
                        done_s = 1'b1;
                        oc_s   = ones_inc_s - HALF_C;
                        cnt_s  = ZERO_C;
                        ones_s = ZERO_C;
`ifdef SDEC_BI_CONT_EN
                        state_s = ACC;
`else
                        state_s = IDLE;
`endif
                    end else begin
                        cnt_s  = cnt_r + ONE_C;
                        ones_s = ones_inc_s;
                    end
                end else begin
                    state_s = ACC;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ZERO_C;
                ones_s  = ZERO_C;
            end
        endcase
    end

    // Counters and registered outputs; a reset discards any partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= ZERO_C;
            ones_r <= ZERO_C;
            oc_r   <= ZERO_C;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            ones_r <= ones_s;
            oc_r   <= oc_s;
            done_r <= done_s;
            busy_r <= (state_s == ACC);
        end
    end

    assign oBusy = busy_r;
    assign oDone = done_r;
    assign oC    = oc_r;

endmodule

// File: tb/tb_sdec_bi_cnt.sv
// Self-checking bench for sdec_bi_cnt: table of window patterns driven
// through a scoreboard, plus reset-mid-window and start-reprobe sequences.
module tb_sdec_bi_cnt;

    localparam int INWD = 8;
    localparam int N    = 256;
`ifdef SDEC_BI_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef struct {
        string name;
        int    kind;       // 0 ones, 1 zeros, 2 alternating, 3 192/64, 4 random
        int    vkind;      // 0 always valid, 1 invalid every third cycle
        bit    use_model;  // expected value from running ones count
        int    exp_oc;
    } vec_t;

    typedef struct {
        string name;
        int    oc;
        int    cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic iBit;
    logic iValid;
    logic oBusy;
    logic oDone;
    logic signed [INWD:0] oC;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   prev_done = 1'b0;
    exp_t sb_q[$];
    vec_t tbl[6];

    sdec_bi_cnt #(.INWD(INWD)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .iBit   (iBit),
        .iValid (iValid),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oC     (oC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time results.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic bit bitval(input int kind, input int idx);
        case (kind)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2) == 0;
            3: return idx < 192;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Scoreboard: compare every oDone pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (oDone) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_oC"}, int'(oC), e.oc);
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_busy"}, int'(oBusy), int'(CONT));
            end
            if (prev_done) chk("done_width", 2, 1);
        end
        prev_done = oDone;
    end

    // Drive one window of N valid bits; entered and left #1 after an edge.
    task automatic run_window(input vec_t v, input bit do_start, input bit poke);
        int sc;
        int j;
        int nv;
        int ones;
        bit vb;
        bit bb;
        exp_t e;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        sc = cyc; j = 0; nv = 0; ones = 0;
        while (nv < N) begin
            vb = (v.vkind == 1) ? ((j % 3) != 0) : 1'b1;
            bb = vb ? bitval(v.kind, nv) : 1'($urandom_range(0, 1));
            iValid = vb;
            iBit   = bb;
            start  = poke && ((j == 50) || (vb && nv == N - 1));
            if (vb) begin
                nv++;
                ones += int'(bb);
            end
            if (vb && nv == N) begin
                e.name = v.name;
                e.oc   = v.use_model ? (ones - N / 2) : v.exp_oc;
                e.cyc  = sc + j + 1;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
            j++;
        end
        iValid = 1'b0;
        iBit   = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{name: "all_ones",   kind: 0, vkind: 0, use_model: 1'b0, exp_oc: 128};
        tbl[1] = '{name: "all_zeros",  kind: 1, vkind: 0, use_model: 1'b0, exp_oc: -128};
        tbl[2] = '{name: "alternate",  kind: 2, vkind: 0, use_model: 1'b0, exp_oc: 0};
        tbl[3] = '{name: "gaps_ones",  kind: 0, vkind: 1, use_model: 1'b0, exp_oc: 128};
        tbl[4] = '{name: "random",     kind: 4, vkind: 0, use_model: 1'b1, exp_oc: 0};
        tbl[5] = '{name: "ones192",    kind: 3, vkind: 0, use_model: 1'b0, exp_oc: 64};

        rst = 1'b1; start = 1'b0; iBit = 1'b0; iValid = 1'b0;
        #12;
        chk("reset_busy", int'(oBusy), 0);
        chk("reset_done", int'(oDone), 0);
        chk("reset_oC", int'(oC), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i], CONT ? (i == 0) : 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        chk("after_table_busy", int'(oBusy), int'(CONT));

        // Reset in the middle of a window after 100 ones.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        iValid = 1'b1; iBit = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(oBusy), 0);
        chk("midrst_oC", int'(oC), 0);
        chk("midrst_done", int'(oDone), 0);
        iValid = 1'b0; iBit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("postrst_busy", int'(oBusy), 0);
        v = tbl[1];
        v.name = "postrst_zeros";
        run_window(v, 1'b1, 1'b0);

        if (CONT) begin
            // Three chained windows from the single earlier start.
            for (int k = 0; k < 3; k++) begin
                v = tbl[0];
                v.name = "cont_ones";
                run_window(v, 1'b0, 1'b0);
            end
            chk("cont_busy_held", int'(oBusy), 1);
        end else begin
            // start pulsed during ACC and at the completing edge.
            v = tbl[5];
            v.name = "start_poke";
            run_window(v, 1'b1, 1'b1);
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk("poke_idle_busy", int'(oBusy), 0);
            chk("poke_oC_held", int'(oC), 64);
        end

        for (int w = 0; w < 5 && sb_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
